// File: rtl/change_dispenser.sv
// Coin change dispenser: pays out an owed amount in 10-yuan and 1-yuan coins
// over a 4-phase req/ack handshake with each hopper. Every output is registered.
module change_dispenser (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] amount,
  input  logic       ten_empty,
  input  logic       one_empty,
  input  logic       ten_ack,
  input  logic       one_ack,
  output logic       ten_req,
  output logic       one_req,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [9:0] remaining,
  output logic [6:0] ten_cnt,
  output logic [9:0] one_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StDecide,
    StTenReq,
    StTenWait,
    StOneReq,
    StOneWait,
    StDone,
    StFault
  } state_e;

  localparam logic [9:0] MaxAmount = 10'd999;

  state_e     state_q;
  logic       ten_req_q, one_req_q, busy_q, done_q, fault_q;
  logic [9:0] remaining_q;
  logic [6:0] ten_cnt_q;
  logic [9:0] one_cnt_q;
  logic [9:0] amount_clamped;

  assign amount_clamped = (amount > MaxAmount) ? MaxAmount : amount;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      ten_req_q   <= 1'b0;
      one_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      remaining_q <= '0;
      ten_cnt_q   <= '0;
      one_cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            remaining_q <= amount_clamped;
            ten_cnt_q   <= '0;
            one_cnt_q   <= '0;
            busy_q      <= 1'b1;
            state_q     <= StDecide;
          end
        end
        // Hopper empty flags are re-read on every pass, so tens fall back to ones.
        StDecide: begin
          if (remaining_q >= 10'd10 && !ten_empty) begin
            ten_req_q <= 1'b1;
            state_q   <= StTenReq;
          end else if (remaining_q >= 10'd1 && !one_empty) begin
            one_req_q <= 1'b1;
            state_q   <= StOneReq;
          end else if (remaining_q == 10'd0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            state_q <= StFault;
          end
        end
        StTenReq: begin
          if (ten_ack) begin
            remaining_q <= remaining_q - 10'd10;
            ten_cnt_q   <= ten_cnt_q + 7'd1;
            ten_req_q   <= 1'b0;
            state_q     <= StTenWait;
          end
        end
        StTenWait: begin
          if (!ten_ack) state_q <= StDecide;
        end
        StOneReq: begin
          if (one_ack) begin
            remaining_q <= remaining_q - 10'd1;
            one_cnt_q   <= one_cnt_q + 10'd1;
            one_req_q   <= 1'b0;
            state_q     <= StOneWait;
          end
        end
        StOneWait: begin
          if (!one_ack) state_q <= StDecide;
        end
        StDone: begin
          state_q <= StIdle;
        end
        StFault: begin
          state_q <= StFault;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ten_req   = ten_req_q;
  assign one_req   = one_req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign remaining = remaining_q;
  assign ten_cnt   = ten_cnt_q;
  assign one_cnt   = one_cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes expected payout results,
// a monitor pops and compares them on each done pulse or fault assertion.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [9:0] amount = '0;
  logic       ten_empty = 1'b0;
  logic       one_empty = 1'b0;
  logic       ten_ack = 1'b0;
  logic       one_ack_h = 1'b0;
  logic       one_stray = 1'b0;
  logic       one_ack;
  logic       ten_req, one_req, busy, done, fault;
  logic [9:0] remaining;
  logic [6:0] ten_cnt;
  logic [9:0] one_cnt;

  assign one_ack = one_ack_h | one_stray;

  change_dispenser dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .amount    (amount),
    .ten_empty (ten_empty),
    .one_empty (one_empty),
    .ten_ack   (ten_ack),
    .one_ack   (one_ack),
    .ten_req   (ten_req),
    .one_req   (one_req),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .remaining (remaining),
    .ten_cnt   (ten_cnt),
    .one_cnt   (one_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_fault;
    int rem;
    int tc;
    int oc;
    int n_ten;
    int n_one;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;
  int   pops = 0;

  function automatic void check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  // Hopper models: ack two cycles after req, drop one cycle after req falls.
  initial begin
    forever begin
      @(negedge clk);
      if (ten_req === 1'b1) begin
        @(negedge clk);
        @(negedge clk);
        ten_ack = 1'b1;
        for (int i = 0; i < 100 && ten_req === 1'b1; i++) @(negedge clk);
        @(negedge clk);
        ten_ack = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (one_req === 1'b1) begin
        @(negedge clk);
        @(negedge clk);
        one_ack_h = 1'b1;
        for (int i = 0; i < 100 && one_req === 1'b1; i++) @(negedge clk);
        @(negedge clk);
        one_ack_h = 1'b0;
      end
    end
  end

  // Monitor: counts req pulses per payout and scores each completion.
  initial begin
    int   n_ten = 0, n_one = 0, both = 0;
    logic ten_prev = 1'b0, one_prev = 1'b0, fault_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        n_ten = 0; n_one = 0; both = 0;
        ten_prev = 1'b0; one_prev = 1'b0; fault_prev = 1'b0;
      end else begin
        if (ten_req === 1'b1 && !ten_prev) n_ten++;
        if (one_req === 1'b1 && !one_prev) n_one++;
        if (ten_req === 1'b1 && one_req === 1'b1) both++;
        ten_prev = ten_req;
        one_prev = one_req;
        if (done === 1'b1 || (fault === 1'b1 && !fault_prev)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_completion", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("kind_fault", int'(fault), int'(e.is_fault));
            check("kind_done", int'(done), int'(!e.is_fault));
            check("busy_at_end", int'(busy), 0);
            check("remaining", int'(remaining), e.rem);
            check("ten_cnt", int'(ten_cnt), e.tc);
            check("one_cnt", int'(one_cnt), e.oc);
            check("ten_req_pulses", n_ten, e.n_ten);
            check("one_req_pulses", n_one, e.n_one);
            check("req_overlap", both, 0);
          end
          n_ten = 0; n_one = 0; both = 0;
          pops++;
        end
        fault_prev = fault;
      end
    end
  end

  task automatic push(input bit f, input int rem, input int tc, input int oc,
                      input int nt, input int no);
    exp_t e;
    e.is_fault = f; e.rem = rem; e.tc = tc; e.oc = oc; e.n_ten = nt; e.n_one = no;
    exp_q.push_back(e);
  endtask

  task automatic start_pay(input logic [9:0] amt);
    @(negedge clk);
    amount = amt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_pop(input int target);
    for (int i = 0; i < 3000 && pops < target; i++) @(negedge clk);
    check("completion_timeout", (pops >= target) ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int target;
    repeat (2) @(negedge clk);
    check("rst_ten_req", int'(ten_req), 0);
    check("rst_one_req", int'(one_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_remaining", int'(remaining), 0);
    check("rst_ten_cnt", int'(ten_cnt), 0);
    check("rst_one_cnt", int'(one_cnt), 0);
    reset = 1'b1;

    // 23 with full hoppers
    target = pops + 1;
    push(1'b0, 0, 2, 3, 2, 3);
    start_pay(10'd23);
    wait_pop(target);

    // 0: busy one cycle, done two cycles after start
    target = pops + 1;
    push(1'b0, 0, 0, 0, 0, 0);
    start_pay(10'd0);
    check("zero_busy_c1", int'(busy), 1);
    check("zero_done_c1", int'(done), 0);
    @(negedge clk);
    check("zero_done_c2", int'(done), 1);
    wait_pop(target);
    @(negedge clk);
    check("zero_done_c3", int'(done), 0);

    // 15 with ten hopper empty
    ten_empty = 1'b1;
    target = pops + 1;
    push(1'b0, 0, 0, 15, 0, 15);
    start_pay(10'd15);
    wait_pop(target);
    ten_empty = 1'b0;

    // 27 with one hopper empty -> fault holding 7, later start ignored
    one_empty = 1'b1;
    target = pops + 1;
    push(1'b1, 7, 2, 0, 2, 0);
    start_pay(10'd27);
    wait_pop(target);
    one_empty = 1'b0;
    start_pay(10'd5);
    repeat (20) @(negedge clk);
    check("fault_held", int'(fault), 1);
    check("fault_remaining", int'(remaining), 7);
    check("fault_busy", int'(busy), 0);
    check("fault_one_req", int'(one_req), 0);
    check("fault_ten_cnt", int'(ten_cnt), 2);
    do_reset();
    check("post_reset_fault", int'(fault), 0);

    // 40, reset while second ten_req is up
    start_pay(10'd40);
    for (int i = 0; i < 200 && !(ten_req === 1'b1 && ten_cnt == 7'd1); i++) @(negedge clk);
    check("second_ten_req_seen", int'(ten_req), 1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ten_req", int'(ten_req), 0);
    check("abort_remaining", int'(remaining), 0);
    check("abort_busy", int'(busy), 0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_resume", int'(ten_req), 0);
    target = pops + 1;
    push(1'b0, 0, 0, 5, 0, 5);
    start_pay(10'd5);
    wait_pop(target);

    // 23 again with start pulsed mid-payout and a stray one_ack during TEN_REQ
    target = pops + 1;
    push(1'b0, 0, 2, 3, 2, 3);
    start_pay(10'd23);
    amount = 10'd50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && ten_req !== 1'b1; i++) @(negedge clk);
    one_stray = 1'b1;
    @(negedge clk);
    one_stray = 1'b0;
    check("stray_remaining", int'(remaining), 23);
    check("stray_one_cnt", int'(one_cnt), 0);
    check("stray_ten_req", int'(ten_req), 1);
    wait_pop(target);

    // Over-range amount clamps to 999: 99 tens then 9 ones
    target = pops + 1;
    push(1'b0, 0, 99, 9, 99, 9);
    start_pay(10'd1023);
    check("clamp_remaining", int'(remaining), 999);
    wait_pop(target);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: system clock; all state updates on rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-003 The block SHALL have port start, input, 1 bit: request to pay out `amount`; sampled only in IDLE.
REQ-004 The block SHALL have port amount, input, 10 bits: change owed, unsigned whole yuan, 0..999; values above 999 are clamped to 999 at latch.
REQ-005 The block SHALL have ports ten_empty and one_empty, input, 1 bit each: the 10-yuan and 1-yuan hoppers have no coins.
REQ-006 The block SHALL have ports ten_ack and one_ack, input, 1 bit each: hopper acknowledge (4-phase handshake).
REQ-007 The block SHALL have ports ten_req and one_req, output, 1 bit each, registered: eject one coin of that denomination.
REQ-008 The block SHALL have port busy, output, 1 bit: payout in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when payout completes.
REQ-010 The block SHALL have port fault, output, 1 bit: payout cannot complete; held until reset.
REQ-011 The block SHALL have port remaining, output, 10 bits: change still owed.
REQ-012 The block SHALL have ports ten_cnt (7 bits) and one_cnt (10 bits), output: coins ejected in the current or last payout.

Function
REQ-013 The block SHALL implement states IDLE, DECIDE, TEN_REQ, TEN_WAIT, ONE_REQ, ONE_WAIT, DONE and FAULT.
REQ-014 IDLE with start=1 SHALL latch the clamped amount into remaining, clear ten_cnt and one_cnt, and go to DECIDE; busy SHALL be 1 from the next cycle.
REQ-015 DECIDE SHALL choose, in priority order: remaining>=10 and !ten_empty -> TEN_REQ; remaining>=1 and !one_empty -> ONE_REQ; remaining==0 -> DONE; otherwise -> FAULT.
REQ-016 ten_req SHALL be 1 exactly while in TEN_REQ; one_req SHALL be 1 exactly while in ONE_REQ; ten_req and one_req SHALL never both be 1.
REQ-017 In TEN_REQ, ten_ack=1 SHALL, on the same edge, subtract 10 from remaining, increment ten_cnt, and go to TEN_WAIT; ten_req SHALL drop on the next cycle.
REQ-018 In TEN_WAIT, ten_ack=0 SHALL move to DECIDE; while ack stays high the block SHALL wait indefinitely.
REQ-019 ONE_REQ and ONE_WAIT SHALL behave as REQ-017 and REQ-018, using one_ack, a decrement of 1, and one_cnt.
REQ-020 The wrong-denomination ack (for example one_ack while in TEN_REQ) SHALL be ignored.
REQ-021 DONE SHALL assert done for one cycle with busy=0, then return to IDLE.
REQ-022 A start with amount=0 SHALL produce IDLE->DECIDE->DONE: done pulses 2 cycles after start, and no req is issued.
REQ-023 When the ten hopper is empty, the tens portion SHALL be paid in ones; an empty flag SHALL be re-evaluated at every DECIDE.
REQ-024 FAULT SHALL hold fault=1, busy=0, req=0, and the frozen remaining and cnt values; start SHALL be ignored; only reset exits FAULT.
REQ-025 start in any state other than IDLE SHALL be ignored, and amount SHALL be sampled only on the start edge.
REQ-026 remaining SHALL never underflow, since a decrement occurs only when REQ-015 guarantees the value covers it.
REQ-027 Worst case, the block SHALL pay 99 tens plus 9 ones; ten_cnt SHALL not wrap, and one_cnt SHALL not exceed 999.

Reset
REQ-028 reset=0 at a clock edge SHALL force IDLE, with ten_req, one_req, busy, done and fault all 0, and remaining, ten_cnt and one_cnt all 0.
REQ-029 Reset mid-handshake SHALL drop any req on the next cycle; the owed amount SHALL be discarded and not resumed.
REQ-030 Every output SHALL come directly from a register; there SHALL be no combinational input-to-output path.

Verification
REQ-031 amount=23, hoppers full, ack returns 2 cycles after req and drops 1 cycle later -> 2 ten_req then 3 one_req, ten_cnt=2, one_cnt=3, remaining=0, one done pulse.
REQ-032 amount=0 with start -> done 2 cycles later, no req asserted, busy=1 for exactly 1 cycle.
REQ-033 amount=15 with ten_empty=1 -> 15 one_req handshakes, ten_cnt=0, one_cnt=15, done.
REQ-034 amount=27 with one_empty=1 -> 2 tens paid, then FAULT with fault=1, remaining=7; a later start has no effect until reset.
REQ-035 amount=40, reset=0 while ten_req=1 during the second coin -> next cycle ten_req=0, IDLE, remaining=0; a fresh start with amount=5 then completes normally.
REQ-036 start pulsed during busy with a different amount, plus stray one_ack during TEN_REQ -> no change to remaining or state; original payout completes.
